// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, op type, legality check and slot state encoding.
// Used by alu_unit, alu_rsp_slot, alu_arbiter and the instruction decoder.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;
    localparam alu_op_t ALU_XOR = 4'b1000;
    localparam alu_op_t ALU_SLL = 4'b1001;
    localparam alu_op_t ALU_SRL = 4'b1010;
    localparam alu_op_t ALU_SRA = 4'b1011;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic is_legal_op(input alu_op_t op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
            ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response slot for a single requester: EMPTY/FULL FSM, captured result/zero/err,
// and the eligibility signal used by the arbiter (pass-through drain when the consumer is ready).
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              rsp_ready,
    input  logic              grant,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_err,
    output logic              eligible,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    // Next state, capture of granted op, and eligibility.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        eligible = req_valid & ((state_q == SLOT_EMPTY) | rsp_ready);
        case (state_q)
            SLOT_EMPTY: begin
                if (grant) begin
                    state_d = SLOT_FULL;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (grant) begin
                    state_d = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (grant) begin
            result_d = alu_result;
            zero_d   = alu_zero;
            err_d    = alu_err;
        end else begin
            result_d = result_q;
            zero_d   = zero_q;
            err_d    = err_q;
        end
    end

    // Slot state and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SLOT_EMPTY;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == SLOT_FULL);
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule

// File: rtl/alu_unit.sv
// Combinational ALU. Shift amount comes from in_1[4:0]; the value shifted is in_2.
// Illegal op codes produce result 0 (and therefore zero 1).
module alu_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   in_1,
    input  logic [DATA_W-1:0]   in_2,
    output logic [DATA_W-1:0]   result,
    output logic                zero
);

    logic [4:0] shamt_s;
    logic       slt_s;

    // Operation select and zero flag.
    always_comb begin
        shamt_s = in_1[4:0];
        slt_s   = ($signed(in_1) < $signed(in_2));
        result  = '0;
        case (alu_op)
            ALU_AND: result = in_1 & in_2;
            ALU_OR:  result = in_1 | in_2;
            ALU_ADD: result = in_1 + in_2;
            ALU_SUB: result = in_1 - in_2;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt_s};
            ALU_XOR: result = in_1 ^ in_2;
            ALU_SLL: result = in_2 << shamt_s;
            ALU_SRL: result = in_2 >> shamt_s;
            ALU_SRA: result = $signed(in_2) >>> shamt_s;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu_unit between two requesters, one op per cycle in total.
// Optional grant/conflict counters are enabled with `define ALU_ARB_PERF_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in_1,
    input  logic [DATA_W-1:0] req0_in_2,
    input  logic [OP_W-1:0]   req0_alu_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in_1,
    input  logic [DATA_W-1:0] req1_in_2,
    input  logic [OP_W-1:0]   req1_alu_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_err
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]       perf0_grants,
    output logic [15:0]       perf1_grants,
    output logic [15:0]       perf_conflicts
`endif
);

    logic              elig0_s, elig1_s;
    logic              grant0_s, grant1_s, contested_s;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] alu_in_1_s, alu_in_2_s, alu_result_s;
    logic [OP_W-1:0]   alu_op_s;
    logic              alu_zero_s, alu_err_s;

    // Round-robin grant: on contention the requester that lost last time wins.
    always_comb begin
        contested_s  = elig0_s & elig1_s;
        grant0_s     = elig0_s & (~elig1_s | last_grant_q);
        grant1_s     = elig1_s & (~elig0_s | ~last_grant_q);
        last_grant_d = last_grant_q;
        if (contested_s) begin
            last_grant_d = grant1_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (grant1_s) begin
            alu_in_1_s = req1_in_1;
            alu_in_2_s = req1_in_2;
            alu_op_s   = req1_alu_op;
        end else begin
            alu_in_1_s = req0_in_1;
            alu_in_2_s = req0_in_2;
            alu_op_s   = req0_alu_op;
        end
        alu_err_s = ~is_legal_op(alu_op_s);
    end

    // Priority pointer; reset value 1 lets requester 0 win the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    alu_unit #(.DATA_W(DATA_W)) u_alu (
        .alu_op (alu_op_s),
        .in_1   (alu_in_1_s),
        .in_2   (alu_in_2_s),
        .result (alu_result_s),
        .zero   (alu_zero_s)
    );

    alu_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req0_valid),
        .rsp_ready  (rsp0_ready),
        .grant      (grant0_s),
        .alu_result (alu_result_s),
        .alu_zero   (alu_zero_s),
        .alu_err    (alu_err_s),
        .eligible   (elig0_s),
        .rsp_valid  (rsp0_valid),
        .rsp_result (rsp0_result),
        .rsp_zero   (rsp0_zero),
        .rsp_err    (rsp0_err)
    );

    alu_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req1_valid),
        .rsp_ready  (rsp1_ready),
        .grant      (grant1_s),
        .alu_result (alu_result_s),
        .alu_zero   (alu_zero_s),
        .alu_err    (alu_err_s),
        .eligible   (elig1_s),
        .rsp_valid  (rsp1_valid),
        .rsp_result (rsp1_result),
        .rsp_zero   (rsp1_zero),
        .rsp_err    (rsp1_err)
    );

`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf0_q, perf0_d, perf1_q, perf1_d, conf_q, conf_d;

    // Wrapping grant and conflict counters.
    always_comb begin
        perf0_d = perf0_q;
        perf1_d = perf1_q;
        conf_d  = conf_q;
        if (grant0_s) begin
            perf0_d = perf0_q + 16'd1;
        end else begin
            perf0_d = perf0_q;
        end
        if (grant1_s) begin
            perf1_d = perf1_q + 16'd1;
        end else begin
            perf1_d = perf1_q;
        end
        if (contested_s) begin
            conf_d = conf_q + 16'd1;
        end else begin
            conf_d = conf_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf0_q <= 16'd0;
            perf1_q <= 16'd0;
            conf_q  <= 16'd0;
        end else begin
            perf0_q <= perf0_d;
            perf1_q <= perf1_d;
            conf_q  <= conf_d;
        end
    end

    assign perf0_grants   = perf0_q;
    assign perf1_grants   = perf1_q;
    assign perf_conflicts = conf_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; counter checks only when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] req0_in_1, req0_in_2, req1_in_1, req1_in_2, rsp0_result, rsp1_result;
    logic [3:0]  req0_alu_op, req1_alu_op;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf0_grants, perf1_grants, perf_conflicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_in_1   (req0_in_1),
        .req0_in_2   (req0_in_2),
        .req0_alu_op (req0_alu_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .rsp0_err    (rsp0_err),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_in_1   (req1_in_1),
        .req1_in_2   (req1_in_2),
        .req1_alu_op (req1_alu_op),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .rsp1_err    (rsp1_err)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf0_grants   (perf0_grants),
        .perf1_grants   (perf1_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_alu_op = op; req0_in_1 = a; req0_in_2 = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_alu_op = op; req1_in_1 = a; req1_in_2 = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive0(1'b0, 4'b0000, 32'd0, 32'd0);
        drive1(1'b0, 4'b0000, 32'd0, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp0_valid",  {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp0_zero",   {31'd0, rsp0_zero}, 32'd0);
        chk("rst_rsp0_err",    {31'd0, rsp0_err}, 32'd0);
        chk("rst_rsp1_valid",  {31'd0, rsp1_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester: ADD 5+7
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, 4'b0010, 32'd5, 32'd7);
        #1;
        chk("single_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("single_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        chk("add_valid",  {31'd0, rsp0_valid}, 32'd1);
        chk("add_result", rsp0_result, 32'd12);
        chk("add_zero",   {31'd0, rsp0_zero}, 32'd0);
        chk("add_err",    {31'd0, rsp0_err}, 32'd0);
        drive0(1'b0, 4'b0010, 32'd5, 32'd7);
        step();
        chk("add_drained", {31'd0, rsp0_valid}, 32'd0);

        // Contention: req0 wins first, then alternation
        drive0(1'b1, 4'b0110, 32'd3, 32'd3);
        drive1(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        #1;
        chk("cont1_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("cont1_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        chk("sub_result", rsp0_result, 32'd0);
        chk("sub_zero",   {31'd0, rsp0_zero}, 32'd1);
        drive0(1'b1, 4'b0000, 32'h0000_00FF, 32'h0000_000F);
        #1;
        chk("cont2_req1_ready", {31'd0, req1_ready}, 32'd1);
        chk("cont2_req0_ready", {31'd0, req0_ready}, 32'd0);
        step();
        chk("or_valid",     {31'd0, rsp1_valid}, 32'd1);
        chk("or_result",    rsp1_result, 32'h0000_00FF);
        chk("rsp0_drained", {31'd0, rsp0_valid}, 32'd0);
        drive1(1'b1, 4'b1000, 32'h0000_00FF, 32'h0000_000F);
        #1;
        chk("cont3_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        chk("and_result", rsp0_result, 32'h0000_000F);
        drive0(1'b0, 4'b0000, 32'd0, 32'd0);
        #1;
        chk("cont4_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        chk("xor_result", rsp1_result, 32'h0000_00F0);
        drive1(1'b0, 4'b0000, 32'd0, 32'd0);
        step();

        // Backpressure: SLL held while rsp0_ready low, then drain+regrant
        rsp0_ready = 1'b0;
        drive0(1'b1, 4'b1001, 32'd4, 32'd1);
        step();
        chk("sll_valid",  {31'd0, rsp0_valid}, 32'd1);
        chk("sll_result", rsp0_result, 32'd16);
        drive0(1'b1, 4'b0111, 32'd3, 32'd5);
        #1;
        chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
        step();
        chk("bp_hold_valid",  {31'd0, rsp0_valid}, 32'd1);
        chk("bp_hold_result", rsp0_result, 32'd16);
        rsp0_ready = 1'b1;
        #1;
        chk("bp_regrant_ready", {31'd0, req0_ready}, 32'd1);
        step();
        chk("slt_valid",  {31'd0, rsp0_valid}, 32'd1);
        chk("slt_result", rsp0_result, 32'd1);
        drive0(1'b0, 4'b0000, 32'd0, 32'd0);
        step();

        // Illegal op on req1, then SRA
        drive1(1'b1, 4'b1111, 32'd9, 32'd9);
        step();
        chk("ill_result", rsp1_result, 32'd0);
        chk("ill_zero",   {31'd0, rsp1_zero}, 32'd1);
        chk("ill_err",    {31'd0, rsp1_err}, 32'd1);
        drive1(1'b1, 4'b1011, 32'd4, 32'h8000_0000);
        step();
        chk("sra_result", rsp1_result, 32'hF800_0000);
        chk("sra_err",    {31'd0, rsp1_err}, 32'd0);
        chk("sra_zero",   {31'd0, rsp1_zero}, 32'd0);
        drive1(1'b0, 4'b0000, 32'd0, 32'd0);
        step();

        // Reset mid-operation with both slots full
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b1, 4'b0010, 32'd1, 32'd1);
        drive1(1'b1, 4'b0010, 32'd2, 32'd2);
        step();
        step();
        chk("mid_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("mid_rsp1_result", rsp1_result, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rsp0_valid",  {31'd0, rsp0_valid}, 32'd0);
        chk("async_rsp1_valid",  {31'd0, rsp1_valid}, 32'd0);
        chk("async_rsp1_result", rsp1_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        drive0(1'b0, 4'b0000, 32'd0, 32'd0);
        drive1(1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);

`ifdef ALU_ARB_PERF_EN
        do_reset();
        chk("perf_rst_conf", {16'd0, perf_conflicts}, 32'd0);
        drive0(1'b1, 4'b0010, 32'd1, 32'd2);
        drive1(1'b1, 4'b0010, 32'd3, 32'd4);
        repeat (3) step();
        drive0(1'b0, 4'b0000, 32'd0, 32'd0);
        drive1(1'b0, 4'b0000, 32'd0, 32'd0);
        step();
        chk("perf_conflicts", {16'd0, perf_conflicts}, 32'd3);
        chk("perf0_grants",   {16'd0, perf0_grants}, 32'd2);
        chk("perf1_grants",   {16'd0, perf1_grants}, 32'd1);
        do_reset();
        drive0(1'b1, 4'b0010, 32'd1, 32'd1);
        repeat (65535) step();
        chk("perf0_ffff", {16'd0, perf0_grants}, 32'h0000_FFFF);
        step();
        chk("perf0_wrap", {16'd0, perf0_grants}, 32'd0);
        drive0(1'b0, 4'b0000, 32'd0, 32'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
